alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//   Iterative shift-add multiplier sequencer that borrows the shared 32-bit ALU.
//   It time-multiplexes the ALU's ADD (4'b0000) and SLL (4'b0111) ops to form the
//   low XLEN bits of op_a*op_b (unsigned; also the correct low half for signed operands).
//   It requests the ALU through a req/gnt pair, so the core datapath keeps priority.
// PARAMETERS
//   XLEN      32  operand/result width; must equal the ALU width (32)
//   CNT_W     5   iteration counter width, $clog2(XLEN)
// PORTS
//   clk         in   1     system clock, all state updates on rising edge
//   rst_n       in   1     asynchronous active-low reset
//   start       in   1     request a multiply; sampled only in IDLE
//   op_a        in   XLEN  multiplicand, latched on accepted start
//   op_b        in   XLEN  multiplier, latched on accepted start
//   busy        out  1     high in every state except IDLE
//   done        out  1     one-cycle pulse, product valid
//   product     out  XLEN  registered result; held until next accepted start
//   alu_req     out  1     high in ADD and SHIFT states
//   alu_gnt     in   1     ALU granted this cycle; state advances only when high
//   alu_in0     out  XLEN  ALU operand 0
//   alu_in1     out  XLEN  ALU operand 1
//   alu_op      out  4     ALU opcode
//   alu_result  in   XLEN  ALU combinational result, same cycle
// BEHAVIOUR
//   - Reset: state=IDLE; acc, mcand, mplier, count, product = 0; busy=done=alu_req=0.
//   - States: IDLE, ADD, SHIFT, DONE. Internal regs acc, mcand, mplier (XLEN), count (CNT_W).
//   - IDLE: on start=1 latch mcand=op_a, mplier=op_b, acc=0, count=0;
//     next = ADD if op_b[0] else SHIFT. start=0 -> stay.
//   - ADD: alu_op=4'b0000, in0=acc, in1=mcand. If alu_gnt: acc<=alu_result, next SHIFT.
//     If !alu_gnt: hold all regs, stay.
//   - SHIFT: alu_op=4'b0111, in0=mcand, in1=1. If alu_gnt: mcand<=alu_result,
//     mplier<=mplier>>1 (local logic), count<=count+1;
//     if count==XLEN-1 -> DONE, else next = ADD if mplier[1] else SHIFT. !alu_gnt: hold.
//   - DONE: product<=acc registered on entry, so product is valid while done=1;
//     done=1 for exactly one cycle, then IDLE.
//   - Outside ADD/SHIFT: alu_in0=alu_in1=0, alu_op=4'b0000, alu_req=0.
//   - Arithmetic: wraps modulo 2^XLEN; overflow bits discarded, no flag.
//   - Latency (gnt always 1): done in cycle XLEN+popcount(op_b)+1 after start edge.
//   - start while busy: ignored, no queueing. start in the DONE cycle: ignored.
//   - gnt dropping mid-operation only stretches latency; result unchanged.
//   - rst_n low mid-operation: immediate return to reset values, no done pulse.
//   - alu_result is ignored when alu_gnt=0.
// CONFIGURATION
//   MUL_SEQ_EARLY_EXIT_EN defined: terminate once no multiplier bits remain.
//     IDLE with op_b==0 -> DONE directly (product=0, done 1 cycle after start).
//     After a granted SHIFT, if (mplier>>1)==0 -> DONE regardless of count.
//     Latency = 2*(msb_index(op_b)+1)-zeros_below_msb+1, at most XLEN+popcount(op_b)+1.
//   Undefined: always XLEN SHIFT iterations; latency fixed by popcount(op_b) as above.
//   Product value is identical in both builds.
// TESTING
//   1 Reset: hold rst_n=0 mid-run -> busy=done=alu_req=0, product=0, idle next start.
//   2 gnt=1, a=7, b=6 -> product=42; done at cycle 35 (no macro), 6 (macro).
//   3 a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> product=32'h0000_0001; done at cycle 65.
//   4 b=0, a=5 -> product=0; done at cycle 33 (no macro), 1 (macro).
//   5 a=3, b=5, alu_gnt toggled 1/0 every cycle -> product=15, regs frozen on gnt=0
//     cycles, alu_req high throughout ADD/SHIFT.
//   6 start pulsed again while busy with a=9, b=9 -> ignored, first product delivered,
//     then new start a=9, b=9 -> product=81.

Source files
------------

// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: req/gnt handshake and operand/result bus between the multiplier sequencer and the shared ALU
// Signals: req (sequencer wants the ALU), gnt (ALU granted this cycle), in0/in1 (operands),
//          op (ALU opcode), result (combinational ALU result, same cycle).
// Modports: master = sequencer side, slave = ALU/arbiter side.
interface alu_mul_seq_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic            gnt;
   logic [XLEN-1:0] in0;
   logic [XLEN-1:0] in1;
   logic [3:0]      op;
   logic [XLEN-1:0] result;
   modport master (output req, in0, in1, op, input gnt, result);
   modport slave  (input req, in0, in1, op, output gnt, result);
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier producing the low XLEN bits of op_a*op_b via the shared ALU
// Ports: clk; rst_n (async active-low); start/op_a/op_b request a multiply (sampled only when idle);
//        busy (not idle), done (one-cycle pulse), product (held result);
//        alu (alu_mul_seq_if.master) borrows the ALU's ADD and SLL ops through a req/gnt pair.
// Option: MUL_SEQ_EARLY_EXIT_EN finishes as soon as no multiplier bits remain; product is unchanged.
module alu_mul_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] product,
   alu_mul_seq_if.master   alu
);
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SLL = 4'b0111;
   typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
   state_t            state_q, state_d;
   logic [XLEN-1:0]   acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, product_q, product_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              busy_q, done_q, req_q;
   logic [XLEN-1:0]   in0, in1;
   logic [3:0]        op;
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      in0      = '0;
      in1      = '0;
      op       = OP_ADD;
      case (state_q)
         IDLE: if (start) begin
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            count_d  = '0;
            state_d  = op_b[0] ? ADD : SHIFT;
`ifdef MUL_SEQ_EARLY_EXIT_EN
            if (op_b == '0) state_d = DONE;
`endif
         end
         ADD: begin
            in0 = acc_q;
            in1 = mcand_q;
            if (alu.gnt) begin
               acc_d   = alu.result;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            op  = OP_SLL;
            in0 = mcand_q;
            in1 = XLEN'(1);
            if (alu.gnt) begin
               mcand_d  = alu.result;
               mplier_d = mplier_q >> 1;
               count_d  = count_q + 1'b1;
               // mplier_q[1] is the multiplier bit that becomes bit 0 after this shift
               state_d  = (count_q == CNT_W'(XLEN - 1)) ? DONE : (mplier_q[1] ? ADD : SHIFT);
`ifdef MUL_SEQ_EARLY_EXIT_EN
               if (mplier_d == '0) state_d = DONE;
`endif
            end
         end
         DONE: state_d = IDLE;
      endcase
      // capture on entry to DONE so product is already valid while done is high
      product_d = (state_d == DONE) ? acc_d : product_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         req_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
         product_q <= product_d;
         busy_q    <= state_d != IDLE;
         done_q    <= state_d == DONE;
         req_q     <= (state_d == ADD) || (state_d == SHIFT);
      end
   end
   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
   assign alu.req = req_q;
   assign alu.in0 = in0;
   assign alu.in1 = in1;
   assign alu.op  = op;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: table-driven and scoreboarded check of the shift-add multiplier sequencer
module tb_alu_mul_seq;
`ifdef MUL_SEQ_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
      int          lat_nm;
      int          lat_ee;
   } vec_t;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, gnt = 1'b1;
   logic [31:0] op_a = '0, op_b = '0, product;
   logic        busy, done;
   int          n_checks = 0, n_fail = 0;
   logic [31:0] sb[$];
   vec_t        vecs[9];
   alu_mul_seq_if #(.XLEN(32)) alu_bus ();
   alu_mul_seq #(.XLEN(32), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .product(product), .alu(alu_bus)
   );
   // shared-ALU model; garbage on the result bus whenever the grant is withheld
   always_comb begin
      alu_bus.gnt    = gnt;
      alu_bus.result = !gnt ? 32'hDEAD_BEEF :
                       (alu_bus.op == 4'b0000) ? alu_bus.in0 + alu_bus.in1 :
                       (alu_bus.op == 4'b0111) ? alu_bus.in0 << alu_bus.in1[4:0] : 32'h0;
   end
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   always @(negedge clk) if (rst_n && done) begin
      if (sb.size() == 0) chk("unexpected_done", {31'd0, done}, 32'd0);
      else chk("product", product, sb.pop_front());
   end
   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                      input int lat, input bit toggle, input bit busy_start);
      int          got = 0, frz = 0, reqbad = 0;
      bit          snap = 1'b0;
      logic [67:0] s_bus = '0;
      op_a = a;
      op_b = b;
      start = 1'b1;
      sb.push_back(p);
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (snap && {alu_bus.in0, alu_bus.in1, alu_bus.op} !== s_bus) frz++;
         if (busy && !done && !alu_bus.req) reqbad++;
         if (done) begin
            got = c;
            break;
         end
         if (busy_start && c == 5) begin
            op_a = 32'd9;
            op_b = 32'd9;
            start = 1'b1;
         end
         snap = 1'b0;
         if (toggle) begin
            gnt = ~gnt;
            if (!gnt) begin
               snap = 1'b1;
               s_bus = {alu_bus.in0, alu_bus.in1, alu_bus.op};
            end
         end
      end
      if (lat >= 0) chk("latency", got, lat);
      else chk("completed", {31'd0, got != 0}, 32'd1);
      if (toggle) begin
         chk("frozen_on_nogrant", frz, 0);
         chk("req_in_add_shift", reqbad, 0);
      end
      gnt = 1'b1;
      op_a = 32'd9;
      op_b = 32'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("idle_after_done", {29'd0, busy, done, alu_bus.req}, 32'd0);
      chk("product_held", product, p);
   endtask
   initial begin
      vecs[0] = '{32'd7, 32'd6, 32'd42, 35, 6};
      vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 65, 65};
      vecs[2] = '{32'd5, 32'd0, 32'd0, 33, 1};
      vecs[3] = '{32'd3, 32'd5, 32'd15, 35, 6};
      vecs[4] = '{32'h1234_5678, 32'd1, 32'h1234_5678, 34, 3};
      vecs[5] = '{32'h8000_0000, 32'd3, 32'h8000_0000, 35, 5};
      vecs[6] = '{32'd2, 32'h8000_0000, 32'd0, 34, 34};
      vecs[7] = '{32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 36, 7};
      vecs[8] = '{32'h1234, 32'h10, 32'h12340, 34, 7};
      repeat (2) @(negedge clk);
      chk("reset_flags", {29'd0, busy, done, alu_bus.req}, 32'd0);
      chk("reset_product", product, 32'd0);
      chk("reset_alu_bus", alu_bus.in0 | alu_bus.in1 | {28'd0, alu_bus.op}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      foreach (vecs[i]) run(vecs[i].a, vecs[i].b, vecs[i].p, EE ? vecs[i].lat_ee : vecs[i].lat_nm, 1'b0, 1'b0);
      run(32'd3, 32'd5, 32'd15, -1, 1'b1, 1'b0);
      run(32'd11, 32'd13, 32'd143, EE ? 8 : 36, 1'b0, 1'b1);
      run(32'd9, 32'd9, 32'd81, EE ? 7 : 35, 1'b0, 1'b0);
      op_a = 32'd100;
      op_b = 32'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("midrun_reset_flags", {29'd0, busy, done, alu_bus.req}, 32'd0);
      chk("midrun_reset_product", product, 32'd0);
      repeat (3) @(negedge clk);
      chk("reset_held_no_done", {30'd0, busy, done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run(32'd7, 32'd6, 32'd42, EE ? 6 : 35, 1'b0, 1'b0);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
